// File: rtl/layer_rr_scheduler.sv
// rtl/layer_rr_scheduler.sv - round-robin sharing of one layer engine among R stream requesters
//
// A requester owns the engine for a whole transaction: N input words are
// forwarded to the engine, then M result words are routed back to the same
// requester. The grant register doubles as the round-robin pointer.
//
// Ports
//   clk         clock, all state on rising edge
//   reset       asynchronous active-low reset (engine shares this net)
//   rq_valid    [R]     requester i offers rq_data[i*T +: T]
//   rq_data     [R*T]   packed input words
//   rq_ready    [R]     input word of requester i accepted
//   rs_valid    [R]     result word valid for requester i
//   rs_data     [T]     shared result bus, qualified by rs_valid
//   rs_ready    [R]     requester i accepts result word
//   l_s_valid   engine s_valid
//   l_data_in   [T]     engine data_in
//   l_s_ready   engine s_ready
//   l_m_valid   engine m_valid
//   l_data_out  [T]     engine data_out
//   l_m_ready   engine m_ready
//   grant       [logR]  owning requester (meaningful while busy)
//   busy        transaction in progress
//   done_cnt    [R*16]  per-requester completed transactions, wrapping

module layer_rr_scheduler #(
  parameter int M    = 4,
  parameter int N    = 4,
  parameter int T    = 16,
  parameter int R    = 2,
  parameter int logR = (R > 1) ? $clog2(R) : 1,
  parameter int logN = $clog2(N + 1),
  parameter int logM = $clog2(M + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [R-1:0]    rq_valid,
  input  logic [R*T-1:0]  rq_data,
  output logic [R-1:0]    rq_ready,
  output logic [R-1:0]    rs_valid,
  output logic [T-1:0]    rs_data,
  input  logic [R-1:0]    rs_ready,
  output logic            l_s_valid,
  output logic [T-1:0]    l_data_in,
  input  logic            l_s_ready,
  input  logic            l_m_valid,
  input  logic [T-1:0]    l_data_out,
  output logic            l_m_ready,
  output logic [logR-1:0] grant,
  output logic            busy,
  output logic [R*16-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t          state, state_d;
  logic [logR-1:0] grant_d;
  logic            busy_d;
  logic [logN-1:0] in_cnt, in_cnt_d;
  logic [logM-1:0] out_cnt, out_cnt_d;
  logic            done_inc;
  logic [15:0]     done_q [R];
  logic [T-1:0]    rq_words [R];
  logic [logR-1:0] pick;
  logic            found;

  for (genvar g = 0; g < R; g++) begin : g_unpack
    assign rq_words[g]           = rq_data[g*T +: T];
    assign done_cnt[g*16 +: 16]  = done_q[g];
  end

  assign rs_data = l_data_out;

  // Search (grant+1)%R ... grant; the sum stays below 2R so one
  // conditional subtraction is enough for the modulo.
  always_comb begin : arb
    logic [logR:0] cand;
    pick  = grant;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= R; k++) begin
      cand = {1'b0, grant} + (logR + 1)'(k);
      if (cand >= (logR + 1)'(R)) cand = cand - (logR + 1)'(R);
      if (!found && rq_valid[cand[logR-1:0]]) begin
        pick  = cand[logR-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    grant_d   = grant;
    busy_d    = busy;
    in_cnt_d  = in_cnt;
    out_cnt_d = out_cnt;
    done_inc  = 1'b0;
    rq_ready  = '0;
    rs_valid  = '0;
    l_s_valid = 1'b0;
    l_m_ready = 1'b0;
    l_data_in = rq_words[grant];

    case (state)
      IDLE: begin
        if (found) begin
          grant_d   = pick;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = FEED;
        end
      end
      FEED: begin
        l_s_valid       = rq_valid[grant];
        rq_ready[grant] = l_s_ready;
        rs_valid[grant] = l_m_valid;
        l_m_ready       = rs_ready[grant];
        if (l_s_valid && l_s_ready) begin
          in_cnt_d = in_cnt + 1'b1;
          if (in_cnt == logN'(N - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        rs_valid[grant] = l_m_valid;
        l_m_ready       = rs_ready[grant];
      end
      default: state_d = IDLE;
    endcase

    // Result beats are honoured in FEED as well; the final one ends the
    // transaction regardless of which of the two states it lands in.
    if (state != IDLE && l_m_valid && l_m_ready) begin
      out_cnt_d = out_cnt + 1'b1;
      if (out_cnt == logM'(M - 1)) begin
        done_inc = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant   <= logR'(R - 1);
      busy    <= 1'b0;
      in_cnt  <= '0;
      out_cnt <= '0;
      for (int r = 0; r < R; r++) done_q[r] <= '0;
    end else begin
      state   <= state_d;
      grant   <= grant_d;
      busy    <= busy_d;
      in_cnt  <= in_cnt_d;
      out_cnt <= out_cnt_d;
      if (done_inc) done_q[grant] <= done_q[grant] + 16'd1;
    end
  end

endmodule
